// File: rtl/counter_pkg.sv
// Shared codes for the upstream counter stage and the event monitor:
// counter mode encodings, event type encodings and the record layout.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_INC  = 2'b00,
    MODE_DEC1 = 2'b01,
    MODE_DEC3 = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  // Bit 1 flags a load edge, bit 0 a carry/borrow; EV_NONE is never stored.
  typedef enum logic [1:0] {
    EV_NONE = 2'b00,
    EV_RCO  = 2'b01,
    EV_LOAD = 2'b10,
    EV_BOTH = 2'b11
  } ev_type_e;

  localparam int REC_W = 8;

  function automatic logic [REC_W-1:0] pack_record(input ev_type_e   ev_type,
                                                   input logic [1:0] mode,
                                                   input logic [3:0] q);
    return {ev_type, mode, q};
  endfunction

endpackage

// File: rtl/event_fifo.sv
// First-word-fall-through FIFO for event records; occupancy counter drives
// full/empty, pointers wrap naturally at power-of-two DEPTH.
module event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  // Head is masked while empty so the output reads zero after reset.
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries data only and is never cleared.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/count_event_monitor.sv
// Watches an upstream counter for carry/borrow and load-edge events, queues a
// record per event cycle, tracks wrap count and a sticky drop flag.
module count_event_monitor
  import counter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             cnt_q,
  input  logic                   cnt_rco,
  input  logic                   cnt_load,
  input  logic [1:0]             cnt_mode,
  input  logic                   ev_ready,
  output logic                   ev_valid,
  output logic [7:0]             ev_data,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [7:0]             wrap_count,
  output logic                   overflow
);

  logic       load_d_q, load_d_d;
  logic [7:0] wrap_count_q, wrap_count_d;
  logic       overflow_q, overflow_d;

  logic       rco_ev, load_ev, any_ev;
  ev_type_e   ev_type;
  logic [7:0] record;
  logic       push, pop, full, empty;

  assign rco_ev  = cnt_rco;
  assign load_ev = cnt_load & ~load_d_q;
  assign any_ev  = rco_ev | load_ev;
  assign ev_type = ev_type_e'({load_ev, rco_ev});
  assign record  = pack_record(ev_type, cnt_mode, cnt_q);

  assign pop  = ~empty & ev_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push = ~reset & any_ev & (~full | pop);

  always_comb begin
    load_d_d     = cnt_load;
    wrap_count_d = wrap_count_q + 8'(rco_ev);
    overflow_d   = overflow_q | (any_ev & full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      load_d_q     <= 1'b0;
      wrap_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      load_d_q     <= load_d_d;
      wrap_count_q <= wrap_count_d;
      overflow_q   <= overflow_d;
    end
  end

  event_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (record),
    .rdata (ev_data),
    .level (fifo_level),
    .full  (full),
    .empty (empty)
  );

  assign ev_valid   = ~empty;
  assign wrap_count = wrap_count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_count_event_monitor.sv
// Directed bench for count_event_monitor with DEPTH=4 and hand-computed records.
module tb_count_event_monitor;
  import counter_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cnt_q;
  logic       cnt_rco;
  logic       cnt_load;
  logic [1:0] cnt_mode;
  logic       ev_ready;
  logic       ev_valid;
  logic [7:0] ev_data;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [7:0] wrap_count;
  logic       overflow;

  int tests_run = 0;
  int tests_failed = 0;

  count_event_monitor #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .cnt_q      (cnt_q),
    .cnt_rco    (cnt_rco),
    .cnt_load   (cnt_load),
    .cnt_mode   (cnt_mode),
    .ev_ready   (ev_ready),
    .ev_valid   (ev_valid),
    .ev_data    (ev_data),
    .fifo_level (fifo_level),
    .wrap_count (wrap_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_level"}, 32'(fifo_level), 0);
    check_eq({tag, "_valid"}, 32'(ev_valid), 0);
    check_eq({tag, "_data"},  32'(ev_data), 0);
    check_eq({tag, "_wrap"},  32'(wrap_count), 0);
    check_eq({tag, "_ovf"},   32'(overflow), 0);
  endtask

  initial begin
    reset = 1'b1; cnt_q = '0; cnt_rco = 1'b0; cnt_load = 1'b0;
    cnt_mode = MODE_INC; ev_ready = 1'b0;
    tick(); tick();
    check_zero("reset");
    reset = 1'b0;

    // Single carry event, mode INC, q=0 -> 8'h40
    cnt_rco = 1'b1; cnt_mode = MODE_INC; cnt_q = 4'h0;
    tick();
    cnt_rco = 1'b0;
    check_eq("rco1_valid", 32'(ev_valid), 1);
    check_eq("rco1_data",  32'(ev_data), 32'h40);
    check_eq("rco1_wrap",  32'(wrap_count), 1);
    check_eq("rco1_level", 32'(fifo_level), 1);
    cnt_q = 4'hF; cnt_mode = MODE_DEC3;
    tick(); tick();
    check_eq("hold_data", 32'(ev_data), 32'h40);
    ev_ready = 1'b1;
    tick();
    check_eq("pop1_valid", 32'(ev_valid), 0);
    tick();
    check_eq("ready_empty_level", 32'(fifo_level), 0);
    ev_ready = 1'b0;

    // Load held 5 cycles -> one record 8'hBA
    cnt_load = 1'b1; cnt_mode = MODE_LOAD; cnt_q = 4'hA;
    for (int i = 0; i < 5; i++) tick();
    cnt_load = 1'b0;
    check_eq("load_level", 32'(fifo_level), 1);
    check_eq("load_data",  32'(ev_data), 32'hBA);
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    check_eq("load_drained", 32'(fifo_level), 0);

    // Carry and load edge together -> single record 8'hF3
    cnt_rco = 1'b1; cnt_load = 1'b1; cnt_mode = MODE_LOAD; cnt_q = 4'h3;
    tick();
    cnt_rco = 1'b0; cnt_load = 1'b0;
    check_eq("both_level", 32'(fifo_level), 1);
    check_eq("both_data",  32'(ev_data), 32'hF3);
    check_eq("both_wrap",  32'(wrap_count), 2);

    // Overflow: six carries into a 4-deep FIFO with no consumer
    do_reset();
    check_eq("rst2_level", 32'(fifo_level), 0);
    cnt_mode = MODE_INC;
    for (int i = 0; i < 6; i++) begin
      cnt_rco = 1'b1; cnt_q = 4'(i);
      tick();
    end
    cnt_rco = 1'b0;
    check_eq("ovf_level", 32'(fifo_level), 4);
    check_eq("ovf_flag",  32'(overflow), 1);
    check_eq("ovf_wrap",  32'(wrap_count), 6);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("ovf_drain%0d", i), 32'(ev_data), 32'h40 | i);
      ev_ready = 1'b1;
      tick();
      ev_ready = 1'b0;
    end
    check_eq("ovf_empty", 32'(ev_valid), 0);
    check_eq("ovf_sticky", 32'(overflow), 1);

    // Full FIFO with simultaneous pop and new event
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cnt_rco = 1'b1; cnt_q = 4'(i); cnt_mode = MODE_INC;
      tick();
    end
    cnt_rco = 1'b1; cnt_q = 4'h9; cnt_mode = MODE_DEC1; ev_ready = 1'b1;
    tick();
    cnt_rco = 1'b0; ev_ready = 1'b0;
    check_eq("fullpp_level", 32'(fifo_level), 4);
    check_eq("fullpp_ovf",   32'(overflow), 0);
    check_eq("fullpp_wrap",  32'(wrap_count), 5);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("fullpp_out%0d", i), 32'(ev_data),
               (i == 3) ? 32'h59 : (32'h41 + i));
      ev_ready = 1'b1;
      tick();
      ev_ready = 1'b0;
    end
    check_eq("fullpp_empty", 32'(ev_valid), 0);

    // 256 carries with a ready consumer wrap the counter back to 0
    do_reset();
    ev_ready = 1'b1; cnt_rco = 1'b1; cnt_mode = MODE_INC; cnt_q = 4'h7;
    for (int i = 0; i < 255; i++) tick();
    check_eq("wrap255",     32'(wrap_count), 255);
    check_eq("burst_level", 32'(fifo_level), 1);
    tick();
    check_eq("wrap0", 32'(wrap_count), 0);
    tick(); tick();
    ev_ready = 1'b0;
    tick(); tick();
    check_eq("burst_ovf_clear", 32'(overflow), 0);
    tick(); tick(); tick();
    check_eq("burst_ovf_set", 32'(overflow), 1);
    reset = 1'b1;
    tick();
    check_zero("midrst");
    cnt_rco = 1'b0;

    // Load held through reset counts as an edge on the first cycle after
    cnt_load = 1'b1; cnt_mode = MODE_DEC3; cnt_q = 4'h5;
    tick();
    check_eq("rstload_ignored", 32'(fifo_level), 0);
    reset = 1'b0;
    tick();
    check_eq("rstload_level", 32'(fifo_level), 1);
    check_eq("rstload_data",  32'(ev_data), 32'hA5);
    tick();
    check_eq("rstload_once", 32'(fifo_level), 1);
    cnt_load = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/count_event_monitor.md
COUNT_EVENT_MONITOR -- requirements
Module: count_event_monitor

Interface
REQ-001 Parameter DEPTH, default 4: event FIFO entries, power of two, 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cnt_q  input  4  counter value from the upstream counter stage.
REQ-005 cnt_rco  input  1  upstream ripple-carry/borrow flag, sampled at rising clk.
REQ-006 cnt_load  input  1  upstream load-active flag, sampled at rising clk.
REQ-007 cnt_mode  input  2  upstream mode: 00 +1, 01 -1, 10 -3, 11 load D.
REQ-008 ev_ready  input  1  downstream consumer accepts the head record.
REQ-009 ev_valid  output  1  FIFO non-empty; head record presented.
REQ-010 ev_data  output  8  head record {type[1:0], mode[1:0], q[3:0]}.
REQ-011 fifo_level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-012 wrap_count  output  8  running count of carry/borrow events.
REQ-013 overflow  output  1  sticky; an event was dropped because the FIFO was full.

Function
REQ-014 Event detection per cycle: rco_ev = cnt_rco; load_ev = cnt_load AND NOT load_d (rising edge of load; load_d is the previous-cycle sample).
REQ-015 Event type: 01 rco only, 10 load only, 11 both in the same cycle (one record, never two); 00 is never written.
REQ-016 Record = {type, cnt_mode, cnt_q}, all sampled in the same cycle as the event.
REQ-017 Push when an event occurs and the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-018 Pop when ev_valid AND ev_ready.
REQ-019 Full and no pop at event: record dropped, overflow set to 1 and held until reset.
REQ-020 Latency: a record pushed at edge N is visible on ev_valid/ev_data after edge N (first-word-fall-through); an empty FIFO never bypasses input to output in the same cycle.
REQ-021 Simultaneous push and pop: fifo_level unchanged; ordering strictly FIFO.
REQ-022 ev_data holds stable while ev_valid=1 and ev_ready=0.
REQ-023 ev_ready while ev_valid=0: no effect.
REQ-024 wrap_count increments by 1 on every cycle with rco_ev=1, including dropped records; wraps 255 -> 0 without flag.
REQ-025 cnt_rco high for k consecutive cycles yields k records and k increments.
REQ-026 cnt_load held high for multiple cycles yields exactly one load record, at the first cycle.
REQ-027 Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH; full/empty derive from fifo_level.

Reset
REQ-028 When reset=1 at a rising edge: fifo_level=0, ev_valid=0, ev_data=0, wrap_count=0, overflow=0, load_d=0, pointers=0.
REQ-029 Reset mid-operation discards all FIFO contents; events sampled in the reset cycle are ignored.
REQ-030 In the first cycle after reset, a high cnt_load counts as a rising edge (load_d=0).

Structure
REQ-031 Shared package counter_pkg holds the mode codes (MODE_INC, MODE_DEC1, MODE_DEC3, MODE_LOAD) and event type codes (EV_RCO, EV_LOAD, EV_BOTH).
REQ-032 The FIFO is one sub-module, event_fifo (parameter DEPTH, width 8, push/pop/level/full/empty); detection, counters and overflow stay in the top.

Verification
REQ-033 Reset, then cnt_rco=1 for 1 cycle with mode=00, q=0 -> ev_valid next cycle, ev_data=8'h40, wrap_count=1, fifo_level=1.
REQ-034 cnt_load=1 held 5 cycles, mode=11, q=4'hA -> exactly one record 8'hBA; fifo_level=1.
REQ-035 cnt_rco=1 and a load rising edge in the same cycle, mode=11, q=3 -> single record 8'hF3.
REQ-036 DEPTH=4, ev_ready=0, 6 rco events -> fifo_level=4, overflow=1, wrap_count=6; then drain -> first 4 records in order, ev_valid=0.
REQ-037 Full FIFO, ev_ready=1 and new event in the same cycle -> fifo_level stays 4, overflow stays 0, new record is last out.
REQ-038 256 rco cycles with ev_ready=1 -> wrap_count returns to 0; reset asserted mid-burst -> all outputs 0 at the next edge.
